// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI memory slave.
// Holds the response and burst encodings, the FSM state types, and the
// next-beat address helper that both channels use.
package axi_mem_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

   // WRAP and the reserved encoding are not supported; they behave as INCR and are flagged.
   function automatic logic burst_bad(input logic [1:0] burst);
      return (burst == BURST_WRAP) || (burst == BURST_RSVD);
   endfunction

   // Wide on purpose: callers truncate and use the bit above their address width as carry.
   function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size,
                                             input logic [1:0] burst);
      if (burst == BURST_FIXED) return addr;
      return addr + (64'd1 << size);
   endfunction

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle between a master and the memory slave.
// slave modport: descriptor/data/ready inputs from the master, ready/response outputs.
// master modport: the mirror image.
interface axi_mem_slave_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
             araddr, arlen, arsize, arburst, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
   );

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
             araddr, arlen, arsize, arburst, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
   );

endinterface

// File: rtl/axi_mem_bank.sv
// Word-addressed storage: one byte-enabled write port, one asynchronous read port.
// Contents are never reset.
// Ports: clk_i, waddr_i/wbe_i/wdata_i (write), raddr_i/rdata_o (read).
module axi_mem_bank #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned WORDS_LOG2 = 10
) (
   input  logic                    clk_i,
   input  logic [WORDS_LOG2-1:0]   waddr_i,
   input  logic [DATA_WIDTH/8-1:0] wbe_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [WORDS_LOG2-1:0]   raddr_i,
   output logic [DATA_WIDTH-1:0]   rdata_o
);
   logic [DATA_WIDTH-1:0] mem [1 << WORDS_LOG2];

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
         if (wbe_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
   end

   // Asynchronous read returns pre-write contents on a same-cycle collision.
   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory-mapped slave with independent write (AW/W/B) and read (AR/R) FSMs.
// Ports: aclk, areset (synchronous, active-high), bus (slave modport of axi_mem_slave_if).
// Responses are OKAY or SLVERR only.
module axi_mem_slave
   import axi_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned MEM_WORDS_LOG2 = 10
) (
   input  logic           aclk,
   input  logic           areset,
   axi_mem_slave_if.slave bus
);
   localparam int unsigned NB      = DATA_WIDTH / 8;
   localparam int unsigned LSB     = $clog2(NB);
   localparam logic [2:0]  SIZE_OK = 3'(LSB);

   typedef logic [ADDR_WIDTH-1:0]     addr_t;
   typedef logic [ADDR_WIDTH:0]       addr_c_t;
   typedef logic [MEM_WORDS_LOG2-1:0] widx_t;

   function automatic addr_c_t adv(input addr_t a, input logic [2:0] size, input logic [1:0] burst);
      return addr_c_t'(next_addr(64'(a), size, burst));
   endfunction

   // ovf marks an address that has wrapped past the top of the address space.
   function automatic logic oob(input addr_t a, input logic ovf);
      return ovf || (64'(a >> LSB) >= (64'd1 << MEM_WORDS_LOG2));
   endfunction

   function automatic widx_t widx(input addr_t a);
      return widx_t'(a >> LSB);
   endfunction

   wr_state_t wr_state_q, wr_state_d;
   addr_t     wr_addr_q, wr_addr_d;
   logic      wr_ovf_q, wr_ovf_d, wr_err_q, wr_err_d;
   logic [7:0] wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
   logic [2:0] wr_size_q, wr_size_d;
   logic [1:0] wr_burst_q, wr_burst_d;
   addr_c_t   wr_nxt;
   logic      wr_oob, wr_is_last, mem_we;

   rd_state_t rd_state_q, rd_state_d;
   addr_t     rd_addr_q, rd_addr_d, cur_addr;
   logic      rd_ovf_q, rd_ovf_d, cur_ovf, rd_load, rd_err;
   logic [7:0] rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
   logic [2:0] rd_size_q, rd_size_d, cur_size;
   logic [1:0] rd_burst_q, rd_burst_d, cur_burst;
   addr_c_t   rd_nxt;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d, mem_rdata;
   logic [1:0] rresp_q, rresp_d;
   logic       rlast_q, rlast_d;
   widx_t      mem_raddr;

   axi_mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORDS_LOG2 (MEM_WORDS_LOG2)
   ) u_bank (
      .clk_i   (aclk),
      .waddr_i (widx(wr_addr_q)),
      .wbe_i   (mem_we ? bus.wstrb : '0),
      .wdata_i (bus.wdata),
      .raddr_i (mem_raddr),
      .rdata_o (mem_rdata)
   );

   // ---------------- write channel ----------------
   always_comb begin
      wr_state_d = wr_state_q;
      wr_addr_d  = wr_addr_q;
      wr_ovf_d   = wr_ovf_q;
      wr_err_d   = wr_err_q;
      wr_len_d   = wr_len_q;
      wr_cnt_d   = wr_cnt_q;
      wr_size_d  = wr_size_q;
      wr_burst_d = wr_burst_q;
      mem_we     = 1'b0;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bresp   = RESP_OKAY;
      wr_nxt     = adv(wr_addr_q, wr_size_q, wr_burst_q);
      wr_oob     = oob(wr_addr_q, wr_ovf_q);
      wr_is_last = (wr_cnt_q == wr_len_q);
      unique case (wr_state_q)
         W_IDLE: begin
            bus.awready = 1'b1;
            if (bus.awvalid) begin
               wr_addr_d  = bus.awaddr;
               wr_len_d   = bus.awlen;
               wr_size_d  = bus.awsize;
               wr_burst_d = bus.awburst;
               wr_cnt_d   = 8'd0;
               wr_ovf_d   = 1'b0;
               wr_err_d   = (bus.awsize != SIZE_OK) || burst_bad(bus.awburst);
               wr_state_d = W_DATA;
            end
         end
         W_DATA: begin
            bus.wready = 1'b1;
            if (bus.wvalid) begin
               mem_we     = (wr_size_q == SIZE_OK) && !wr_oob;
               wr_err_d   = wr_err_q || wr_oob || (bus.wlast != wr_is_last);
               wr_addr_d  = addr_t'(wr_nxt);
               wr_ovf_d   = wr_ovf_q || wr_nxt[ADDR_WIDTH];
               wr_cnt_d   = wr_cnt_q + 8'd1;
               // Beat count, not WLAST, ends the burst.
               if (wr_is_last) wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            bus.bvalid = 1'b1;
            bus.bresp  = wr_err_q ? RESP_SLVERR : RESP_OKAY;
            if (bus.bready) wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   // ---------------- read channel ----------------
   // Beat 0 is looked up straight from AR so it can be registered on the handshake.
   always_comb begin
      if (rd_state_q == R_IDLE) begin
         cur_addr  = bus.araddr;
         cur_ovf   = 1'b0;
         cur_size  = bus.arsize;
         cur_burst = bus.arburst;
      end else begin
         cur_addr  = rd_addr_q;
         cur_ovf   = rd_ovf_q;
         cur_size  = rd_size_q;
         cur_burst = rd_burst_q;
      end
      mem_raddr = widx(cur_addr);
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_addr_d  = rd_addr_q;
      rd_ovf_d   = rd_ovf_q;
      rd_len_d   = rd_len_q;
      rd_cnt_d   = rd_cnt_q;
      rd_size_d  = rd_size_q;
      rd_burst_d = rd_burst_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rlast_d    = rlast_q;
      rd_load    = 1'b0;
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      rd_nxt     = adv(cur_addr, cur_size, cur_burst);
      rd_err     = (cur_size != SIZE_OK) || burst_bad(cur_burst) || oob(cur_addr, cur_ovf);
      unique case (rd_state_q)
         R_IDLE: begin
            bus.arready = 1'b1;
            if (bus.arvalid) begin
               rd_load    = 1'b1;
               rd_len_d   = bus.arlen;
               rd_size_d  = bus.arsize;
               rd_burst_d = bus.arburst;
               rd_cnt_d   = 8'd0;
               rlast_d    = (bus.arlen == 8'd0);
               rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            bus.rvalid = 1'b1;
            if (bus.rready) begin
               if (rlast_q) begin
                  rd_state_d = R_IDLE;
               end else begin
                  rd_load  = 1'b1;
                  rd_cnt_d = rd_cnt_q + 8'd1;
                  rlast_d  = ((rd_cnt_q + 8'd1) == rd_len_q);
               end
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
      if (rd_load) begin
         rdata_d   = rd_err ? '0 : mem_rdata;
         rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
         rd_addr_d = addr_t'(rd_nxt);
         rd_ovf_d  = cur_ovf || rd_nxt[ADDR_WIDTH];
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.rresp = rresp_q;
   assign bus.rlast = rlast_q;

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_state_q <= W_IDLE;
         wr_addr_q  <= '0;
         wr_ovf_q   <= 1'b0;
         wr_err_q   <= 1'b0;
         wr_len_q   <= 8'd0;
         wr_cnt_q   <= 8'd0;
         wr_size_q  <= 3'd0;
         wr_burst_q <= BURST_FIXED;
         rd_state_q <= R_IDLE;
         rd_addr_q  <= '0;
         rd_ovf_q   <= 1'b0;
         rd_len_q   <= 8'd0;
         rd_cnt_q   <= 8'd0;
         rd_size_q  <= 3'd0;
         rd_burst_q <= BURST_FIXED;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         rlast_q    <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         wr_addr_q  <= wr_addr_d;
         wr_ovf_q   <= wr_ovf_d;
         wr_err_q   <= wr_err_d;
         wr_len_q   <= wr_len_d;
         wr_cnt_q   <= wr_cnt_d;
         wr_size_q  <= wr_size_d;
         wr_burst_q <= wr_burst_d;
         rd_state_q <= rd_state_d;
         rd_addr_q  <= rd_addr_d;
         rd_ovf_q   <= rd_ovf_d;
         rd_len_q   <= rd_len_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_size_q  <= rd_size_d;
         rd_burst_q <= rd_burst_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rlast_q    <= rlast_d;
      end
   end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave (32-bit data, 16-bit address, 1024 words).
// Inputs change and outputs are sampled on the falling edge.
module tb_axi_mem_slave;
   import axi_mem_pkg::*;

   logic aclk = 1'b0;
   logic areset = 1'b1;
   int   total = 0;
   int   bad = 0;

   logic [31:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];
   logic [1:0]  b_resp;

   axi_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

   axi_mem_slave #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (16),
      .MEM_WORDS_LOG2 (10)
   ) dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (bus)
   );

   always #5 aclk = ~aclk;

   // ---------------- bus driving helpers (called on a falling edge) ----------------
   task automatic do_aw(input logic [15:0] a, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst);
      int n = 0;
      bus.awaddr = a; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
      bus.awvalid = 1'b1;
      while (bus.awready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) begin total++; bad++; $display("FAIL aw_timeout awready=%b want=1", bus.awready); end
      @(negedge aclk);
      bus.awvalid = 1'b0;
   endtask

   task automatic do_ar(input logic [15:0] a, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst);
      int n = 0;
      bus.araddr = a; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
      bus.arvalid = 1'b1;
      while (bus.arready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) begin total++; bad++; $display("FAIL ar_timeout arready=%b want=1", bus.arready); end
      @(negedge aclk);
      bus.arvalid = 1'b0;
   endtask

   task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic l);
      int n = 0;
      bus.wdata = d; bus.wstrb = s; bus.wlast = l; bus.wvalid = 1'b1;
      while (bus.wready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) begin total++; bad++; $display("FAIL w_timeout wready=%b want=1", bus.wready); end
      @(negedge aclk);
      bus.wvalid = 1'b0;
   endtask

   task automatic get_b();
      int n = 0;
      bus.bready = 1'b1;
      while (bus.bvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) begin total++; bad++; $display("FAIL b_timeout bvalid=%b want=1", bus.bvalid); end
      b_resp = bus.bresp;
      @(negedge aclk);
      bus.bready = 1'b0;
   endtask

   task automatic read_burst(input logic [15:0] a, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst);
      int n;
      do_ar(a, len, size, burst);
      bus.rready = 1'b1;
      for (int k = 0; k <= int'(len); k++) begin
         n = 0;
         while (bus.rvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
         if (n >= 50) begin total++; bad++; $display("FAIL r_timeout rvalid=%b want=1", bus.rvalid); end
         rd_data[k] = bus.rdata; rd_resp[k] = bus.rresp; rd_last[k] = bus.rlast;
         @(negedge aclk);
      end
      bus.rready = 1'b0;
   endtask

   task automatic write1(input logic [15:0] a, input logic [31:0] d);
      do_aw(a, 8'd0, 3'd2, BURST_INCR);
      do_w(d, 4'hF, 1'b1);
      get_b();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      areset = 1'b1;
      repeat (3) @(negedge aclk);
      total++; if (bus.awready !== 1'b1) begin bad++; $display("FAIL rst_awready got=%b want=1", bus.awready); end
      total++; if (bus.wready !== 1'b0) begin bad++; $display("FAIL rst_wready got=%b want=0", bus.wready); end
      total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%b want=0", bus.bvalid); end
      total++; if (bus.bresp !== 2'b00) begin bad++; $display("FAIL rst_bresp got=%b want=00", bus.bresp); end
      total++; if (bus.arready !== 1'b1) begin bad++; $display("FAIL rst_arready got=%b want=1", bus.arready); end
      total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", bus.rvalid); end
      total++; if (bus.rlast !== 1'b0) begin bad++; $display("FAIL rst_rlast got=%b want=0", bus.rlast); end
      total++; if (bus.rresp !== 2'b00) begin bad++; $display("FAIL rst_rresp got=%b want=00", bus.rresp); end
      total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.rdata); end
      areset = 1'b0;
      @(negedge aclk);
   endtask

   task automatic test_single();
      write1(16'h0010, 32'hDEADBEEF);
      total++; if (b_resp !== 2'b00) begin bad++; $display("FAIL single_bresp got=%b want=00", b_resp); end
      bus.araddr = 16'h0010; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = BURST_INCR;
      bus.arvalid = 1'b1;
      total++; if (bus.arready !== 1'b1) begin bad++; $display("FAIL single_arready got=%b want=1", bus.arready); end
      @(negedge aclk);
      bus.arvalid = 1'b0;
      total++; if (bus.rvalid !== 1'b1) begin bad++; $display("FAIL single_rvalid_lat got=%b want=1", bus.rvalid); end
      total++; if (bus.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%h want=deadbeef", bus.rdata); end
      total++; if (bus.rresp !== 2'b00) begin bad++; $display("FAIL single_rresp got=%b want=00", bus.rresp); end
      total++; if (bus.rlast !== 1'b1) begin bad++; $display("FAIL single_rlast got=%b want=1", bus.rlast); end
      bus.rready = 1'b1;
      @(negedge aclk);
      bus.rready = 1'b0;
      total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL single_rvalid_drop got=%b want=0", bus.rvalid); end
   endtask

   task automatic test_incr4();
      logic [31:0] exp [4];
      exp[0] = 32'h11111111; exp[1] = 32'h22222222; exp[2] = 32'hAAAA3333; exp[3] = 32'h44444444;
      write1(16'h0108, 32'hAAAAAAAA);
      do_aw(16'h0100, 8'd3, 3'd2, BURST_INCR);
      do_w(32'h11111111, 4'hF, 1'b0);
      do_w(32'h22222222, 4'hF, 1'b0);
      do_w(32'h33333333, 4'b0011, 1'b0);
      do_w(32'h44444444, 4'hF, 1'b1);
      get_b();
      total++; if (b_resp !== 2'b00) begin bad++; $display("FAIL incr4_bresp got=%b want=00", b_resp); end
      read_burst(16'h0100, 8'd3, 3'd2, BURST_INCR);
      for (int k = 0; k < 4; k++) begin
         total++; if (rd_data[k] !== exp[k]) begin bad++; $display("FAIL incr4_data%0d got=%h want=%h", k, rd_data[k], exp[k]); end
         total++; if (rd_last[k] !== (k == 3)) begin bad++; $display("FAIL incr4_last%0d got=%b want=%b", k, rd_last[k], (k == 3)); end
         total++; if (rd_resp[k] !== 2'b00) begin bad++; $display("FAIL incr4_resp%0d got=%b want=00", k, rd_resp[k]); end
      end
   endtask

   task automatic test_oob();
      do_aw(16'h0FFC, 8'd1, 3'd2, BURST_INCR);
      do_w(32'h12345678, 4'hF, 1'b0);
      do_w(32'h9ABCDEF0, 4'hF, 1'b1);
      get_b();
      total++; if (b_resp !== 2'b10) begin bad++; $display("FAIL oob_bresp got=%b want=10", b_resp); end
      read_burst(16'h0FFC, 8'd1, 3'd2, BURST_INCR);
      total++; if (rd_data[0] !== 32'h12345678) begin bad++; $display("FAIL oob_data0 got=%h want=12345678", rd_data[0]); end
      total++; if (rd_resp[0] !== 2'b00) begin bad++; $display("FAIL oob_resp0 got=%b want=00", rd_resp[0]); end
      total++; if (rd_data[1] !== 32'h0) begin bad++; $display("FAIL oob_data1 got=%h want=0", rd_data[1]); end
      total++; if (rd_resp[1] !== 2'b10) begin bad++; $display("FAIL oob_resp1 got=%b want=10", rd_resp[1]); end
      total++; if (rd_last[1] !== 1'b1) begin bad++; $display("FAIL oob_last1 got=%b want=1", rd_last[1]); end
   endtask

   task automatic test_backpressure();
      int k = 0;
      int cyc = 0;
      logic stalled = 1'b0;
      logic [31:0] held = '0;
      do_aw(16'h0200, 8'd0, 3'd2, BURST_INCR);
      do_w(32'h00000055, 4'hF, 1'b1);
      for (int i = 0; i < 5; i++) begin
         total++; if (bus.bvalid !== 1'b1) begin bad++; $display("FAIL bp_bvalid c%0d got=%b want=1", i, bus.bvalid); end
         total++; if (bus.bresp !== 2'b00) begin bad++; $display("FAIL bp_bresp c%0d got=%b want=00", i, bus.bresp); end
         total++; if (bus.awready !== 1'b0) begin bad++; $display("FAIL bp_awready c%0d got=%b want=0", i, bus.awready); end
         @(negedge aclk);
      end
      get_b();
      total++; if (b_resp !== 2'b00) begin bad++; $display("FAIL bp_bresp_final got=%b want=00", b_resp); end
      do_aw(16'h0300, 8'd3, 3'd2, BURST_INCR);
      do_w(32'h0000A001, 4'hF, 1'b0);
      do_w(32'h0000A002, 4'hF, 1'b0);
      do_w(32'h0000A003, 4'hF, 1'b0);
      do_w(32'h0000A004, 4'hF, 1'b1);
      get_b();
      do_ar(16'h0300, 8'd3, 3'd2, BURST_INCR);
      while (k < 4 && cyc < 60) begin
         if (bus.rvalid === 1'b1) begin
            if (stalled) begin
               total++; if (bus.rdata !== held) begin bad++; $display("FAIL bp_stall_stable got=%h want=%h", bus.rdata, held); end
            end
            bus.rready = ((cyc % 3) != 0);
            if (bus.rready) begin
               total++; if (bus.rdata !== 32'h0000A001 + 32'(k)) begin bad++; $display("FAIL bp_rdata%0d got=%h want=%h", k, bus.rdata, 32'h0000A001 + 32'(k)); end
               total++; if (bus.rlast !== (k == 3)) begin bad++; $display("FAIL bp_rlast%0d got=%b want=%b", k, bus.rlast, (k == 3)); end
               k++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = bus.rdata;
            end
         end else begin
            bus.rready = 1'b0;
         end
         @(negedge aclk);
         cyc++;
      end
      bus.rready = 1'b0;
      total++; if (k !== 4) begin bad++; $display("FAIL bp_beats got=%0d want=4", k); end
   endtask

   task automatic test_concurrent();
      write1(16'h0080, 32'h0BADF00D);
      do_aw(16'h0080, 8'd0, 3'd2, BURST_INCR);
      bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
      bus.araddr = 16'h0080; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = BURST_INCR;
      bus.arvalid = 1'b1;
      total++; if ({bus.wready, bus.arready} !== 2'b11) begin bad++; $display("FAIL cc_ready got=%b want=11", {bus.wready, bus.arready}); end
      @(negedge aclk);
      bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      total++; if (bus.rdata !== 32'h0BADF00D) begin bad++; $display("FAIL cc_old_data got=%h want=0badf00d", bus.rdata); end
      bus.rready = 1'b1;
      @(negedge aclk);
      bus.rready = 1'b0;
      get_b();
      total++; if (b_resp !== 2'b00) begin bad++; $display("FAIL cc_bresp got=%b want=00", b_resp); end
      read_burst(16'h0080, 8'd0, 3'd2, BURST_INCR);
      total++; if (rd_data[0] !== 32'hCAFEF00D) begin bad++; $display("FAIL cc_new_data got=%h want=cafef00d", rd_data[0]); end
   endtask

   task automatic test_errors();
      do_aw(16'h0080, 8'd0, 3'd1, BURST_INCR);
      do_w(32'h11112222, 4'hF, 1'b1);
      get_b();
      total++; if (b_resp !== 2'b10) begin bad++; $display("FAIL err_size_bresp got=%b want=10", b_resp); end
      read_burst(16'h0080, 8'd0, 3'd2, BURST_INCR);
      total++; if (rd_data[0] !== 32'hCAFEF00D) begin bad++; $display("FAIL err_size_nowrite got=%h want=cafef00d", rd_data[0]); end
      read_burst(16'h0080, 8'd0, 3'd1, BURST_INCR);
      total++; if ({rd_resp[0], rd_data[0]} !== {2'b10, 32'h0}) begin bad++; $display("FAIL err_arsize got=%b/%h want=10/0", rd_resp[0], rd_data[0]); end
      read_burst(16'h0080, 8'd0, 3'd2, BURST_WRAP);
      total++; if ({rd_resp[0], rd_data[0]} !== {2'b10, 32'h0}) begin bad++; $display("FAIL err_wrap got=%b/%h want=10/0", rd_resp[0], rd_data[0]); end
      do_aw(16'h0504, 8'd1, 3'd2, BURST_INCR);
      do_w(32'h00000001, 4'hF, 1'b1);
      do_w(32'h00000002, 4'hF, 1'b1);
      get_b();
      total++; if (b_resp !== 2'b10) begin bad++; $display("FAIL err_wlast got=%b want=10", b_resp); end
      do_aw(16'h0500, 8'd1, 3'd2, BURST_FIXED);
      do_w(32'h0000F1F1, 4'hF, 1'b0);
      do_w(32'h0000F2F2, 4'hF, 1'b1);
      get_b();
      total++; if (b_resp !== 2'b00) begin bad++; $display("FAIL fixed_bresp got=%b want=00", b_resp); end
      read_burst(16'h0500, 8'd1, 3'd2, BURST_FIXED);
      total++; if ({rd_data[0], rd_data[1]} !== {32'h0000F2F2, 32'h0000F2F2}) begin bad++; $display("FAIL fixed_data got=%h,%h want=0000f2f2,0000f2f2", rd_data[0], rd_data[1]); end
      total++; if ({rd_last[0], rd_last[1]} !== 2'b01) begin bad++; $display("FAIL fixed_last got=%b%b want=01", rd_last[0], rd_last[1]); end
   endtask

   task automatic test_reset_mid();
      do_aw(16'h0400, 8'd3, 3'd2, BURST_INCR);
      do_w(32'h01010101, 4'hF, 1'b0);
      do_w(32'h02020202, 4'hF, 1'b0);
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      total++; if (bus.awready !== 1'b1) begin bad++; $display("FAIL rm_awready got=%b want=1", bus.awready); end
      total++; if (bus.wready !== 1'b0) begin bad++; $display("FAIL rm_wready got=%b want=0", bus.wready); end
      for (int i = 0; i < 4; i++) begin
         total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL rm_bvalid c%0d got=%b want=0", i, bus.bvalid); end
         @(negedge aclk);
      end
      read_burst(16'h0400, 8'd1, 3'd2, BURST_INCR);
      total++; if (rd_data[0] !== 32'h01010101) begin bad++; $display("FAIL rm_beat0 got=%h want=01010101", rd_data[0]); end
      total++; if (rd_data[1] !== 32'h02020202) begin bad++; $display("FAIL rm_beat1 got=%h want=02020202", rd_data[1]); end
   endtask

   initial begin
      bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = BURST_INCR;
      bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = BURST_INCR;
      bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      test_reset();
      test_single();
      test_incr4();
      test_oob();
      test_backpressure();
      test_concurrent();
      test_errors();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
